sample_framer: RTL

//  Upstream stage of the distributor. Collects a serial stream of 8-bit samples (one per
//  i_clk = sampling clock) into a 10-lane frame and publishes it in parallel on o_D0..o_D9

---
 rtl/sample_pkg.sv | 25 ++
 rtl/sample_framer_if.sv | 26 ++
 rtl/framer_idle_timer.sv | 28 ++
 rtl/sample_framer.sv | 94 +++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared types for the sample framer and the downstream distributor.
package sample_pkg;

   localparam int unsigned DW    = 8;
   localparam int unsigned NLANE = 10;
   localparam int unsigned CW    = 4;

   typedef logic [DW-1:0]    sample_t;
   typedef sample_t          frame_t [NLANE];
   typedef logic [NLANE-1:0] lane_mask_t;
   typedef logic [CW-1:0]    count_t;

   typedef enum logic {EMPTY, FILL} fill_state_e;

   // Lane k is set iff k < n (lanes carrying data when n samples are held).
   function automatic lane_mask_t fill_mask(input count_t n);
      lane_mask_t m;
      m = '0;
      for (int unsigned k = 0; k < NLANE; k++) begin
         m[k] = (count_t'(k) < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Sample stream in / published frame out bundle of the sample framer.
interface sample_framer_if;
   import sample_pkg::*;

   logic             i_valid;
   sample_t          i_data;
   logic             o_ready;
   logic             i_flush;
   sample_t          o_D0, o_D1, o_D2, o_D3, o_D4;
   sample_t          o_D5, o_D6, o_D7, o_D8, o_D9;
   lane_mask_t       o_start;
   logic             o_busy;

   modport master (
      output i_valid, i_data, i_flush,
      input  o_ready, o_D0, o_D1, o_D2, o_D3, o_D4,
             o_D5, o_D6, o_D7, o_D8, o_D9, o_start, o_busy
   );

   modport slave (
      input  i_valid, i_data, i_flush,
      output o_ready, o_D0, o_D1, o_D2, o_D3, o_D4,
             o_D5, o_D6, o_D7, o_D8, o_D9, o_start, o_busy
   );

endinterface

// File: rtl/framer_idle_timer.sv
// Saturating idle-cycle counter; tc flags that TIMEOUT idle cycles have elapsed.
// TIMEOUT = 0 disables the terminal count entirely.
module framer_idle_timer #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt;

   // Count enabled idle cycles, hold at TIMEOUT, clear on request.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && (cnt != TW'(TIMEOUT))) begin
         cnt <= cnt + TW'(1);
      end
   end

   assign tc = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/sample_framer.sv
// sample_framer: collects serial samples into a 10-lane frame and publishes it
// with a per-lane start strobe. Partial frames go out on flush or idle timeout.
// Build option PARTIAL_ZERO_FILL_EN: unfilled lanes of a partial publish are
// zeroed; otherwise they keep the previous frame's values.
module sample_framer
   import sample_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic            i_clk,
   input  logic            i_rst,
   sample_framer_if.slave  bus
);

   fill_state_e state_q;
   count_t      count_q, count_nxt;
   frame_t      shadow_q, shadow_nxt, d_q;
   lane_mask_t  start_q, pub_mask;
   logic        busy_q;
   logic        transfer, full_pub, flush_req, publish, tc;

   assign bus.o_ready = ~i_rst;
   assign transfer    = bus.i_valid & bus.o_ready;

   // A simultaneous sample is folded in before deciding what to publish.
   assign count_nxt = count_q + count_t'(transfer);
   assign full_pub  = (count_nxt == count_t'(NLANE));
   assign flush_req = bus.i_flush | tc;
   assign publish   = full_pub | (flush_req & (count_nxt != '0));
   assign pub_mask  = fill_mask(count_nxt);

   // Shadow buffer contents including this cycle's sample.
   always_comb begin
      shadow_nxt = shadow_q;
      if (transfer) begin
         shadow_nxt[count_q] = bus.i_data;
      end
   end

   framer_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk (i_clk),
      .rst (i_rst),
      .clr (transfer | publish),
      .en  ((state_q == FILL) & ~transfer),
      .tc  (tc)
   );

   // Collection state, fill count and registered publish outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= EMPTY;
         count_q  <= '0;
         busy_q   <= 1'b0;
         start_q  <= '0;
         shadow_q <= '{default: '0};
         d_q      <= '{default: '0};
      end else begin
         start_q  <= '0;
         shadow_q <= shadow_nxt;
         if (publish) begin
            state_q <= EMPTY;
            count_q <= '0;
            busy_q  <= 1'b0;
            start_q <= pub_mask;
            for (int unsigned k = 0; k < NLANE; k++) begin
               if (pub_mask[k]) d_q[k] <= shadow_nxt[k];
`ifdef PARTIAL_ZERO_FILL_EN
               else d_q[k] <= '0;
`endif
            end
         end else begin
            state_q <= (count_nxt != '0) ? FILL : EMPTY;
            count_q <= count_nxt;
            busy_q  <= (count_nxt != '0);
         end
      end
   end

   assign bus.o_start = start_q;
   assign bus.o_busy  = busy_q;
   assign bus.o_D0    = d_q[0];
   assign bus.o_D1    = d_q[1];
   assign bus.o_D2    = d_q[2];
   assign bus.o_D3    = d_q[3];
   assign bus.o_D4    = d_q[4];
   assign bus.o_D5    = d_q[5];
   assign bus.o_D6    = d_q[6];
   assign bus.o_D7    = d_q[7];
   assign bus.o_D8    = d_q[8];
   assign bus.o_D9    = d_q[9];

endmodule
